axis_deframer: RTL and testbench

//   Byte-stream deframer with escape removal and error signalling. Hunts for START_BYTE,

---
 rtl/axis_deframer_pkg.sv | 21 ++
 rtl/axis_deframer_oreg.sv | 47 ++++
 rtl/axis_deframer.sv | 157 +++++++++++++++
 tb/tb_axis_deframer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_deframer_pkg.sv
// Shared constants for the byte-stream deframer: FSM state encodings,
// default delimiter bytes and the output beat layout.
package axis_deframer_pkg;

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] DATA    = 2'd1;
  localparam logic [1:0] ESC     = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  localparam logic [7:0] DEF_START_BYTE  = 8'h7D;
  localparam logic [7:0] DEF_STOP_BYTE   = 8'h7E;
  localparam logic [7:0] DEF_ESCAPE_BYTE = 8'h7F;
  localparam int         DEF_MAX_LEN     = 1024;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

endpackage

// File: rtl/axis_deframer_oreg.sv
// Single-stage AXI4-Stream output register. The upstream side may load a new
// beat whenever the register is empty or its current beat is being taken.
module axis_deframer_oreg
  import axis_deframer_pkg::*;
(
  input  logic       aclk,
  input  logic       areset,
  input  logic       load,
  input  beat_t      load_beat,
  output logic       load_ready,
  output logic       initiator_tvalid,
  input  logic       initiator_tready,
  output logic [7:0] initiator_tdata,
  output logic       initiator_tlast,
  output logic       initiator_tuser
);

  logic       valid_reg;
  logic [7:0] data_reg;
  logic       last_reg;
  logic       user_reg;

  always_ff @(posedge aclk) begin
    if (areset) begin
      valid_reg <= 1'b0;
      data_reg  <= 8'h00;
      last_reg  <= 1'b0;
      user_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_beat.data;
      last_reg  <= load_beat.last;
      user_reg  <= load_beat.user;
    end else if (initiator_tready) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      user_reg  <= 1'b0;
    end
  end

  assign load_ready       = !valid_reg || initiator_tready;
  assign initiator_tvalid = valid_reg;
  assign initiator_tdata  = data_reg;
  assign initiator_tlast  = last_reg;
  assign initiator_tuser  = user_reg;

endmodule

// File: rtl/axis_deframer.sv
// Byte-stream deframer: hunts for START, removes escapes, emits AXI4-Stream
// frames with tlast/tuser. Optional counters under AXIS_DEFRAMER_STATS_EN.
module axis_deframer
  import axis_deframer_pkg::*;
#(
  parameter logic [7:0] START_BYTE  = DEF_START_BYTE,
  parameter logic [7:0] STOP_BYTE   = DEF_STOP_BYTE,
  parameter logic [7:0] ESCAPE_BYTE = DEF_ESCAPE_BYTE,
  parameter int         MAX_LEN     = DEF_MAX_LEN
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        target_tvalid,
  output logic        target_tready,
  input  logic [7:0]  target_tdata,
  output logic        initiator_tvalid,
  input  logic        initiator_tready,
  output logic [7:0]  initiator_tdata,
  output logic        initiator_tlast,
  output logic        initiator_tuser
`ifdef AXIS_DEFRAMER_STATS_EN
  ,
  output logic [31:0] frame_cnt,
  output logic [31:0] err_cnt
`endif
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [1:0]       state_reg, state_next;
  logic [7:0]       hold_data_reg, hold_data_next;
  logic             hold_valid_reg, hold_valid_next;
  logic [LEN_W-1:0] len_reg, len_next;

  logic  accept;
  logic  take_payload;
  logic  emit;
  beat_t emit_beat;

  assign accept = target_tvalid && target_tready;

  always_comb begin
    state_next      = state_reg;
    hold_data_next  = hold_data_reg;
    hold_valid_next = hold_valid_reg;
    len_next        = len_reg;
    take_payload    = 1'b0;
    emit            = 1'b0;
    emit_beat       = '{data: hold_data_reg, last: 1'b0, user: 1'b0};

    if (accept) begin
      case (state_reg)
        HUNT: begin
          if (target_tdata == START_BYTE) begin
            state_next      = DATA;
            len_next        = '0;
            hold_valid_next = 1'b0;
          end
        end
        DATA: begin
          if (target_tdata == ESCAPE_BYTE) begin
            state_next = ESC;
          end else if (target_tdata == STOP_BYTE) begin
            emit            = hold_valid_reg;
            emit_beat.last  = 1'b1;
            hold_valid_next = 1'b0;
            state_next      = HUNT;
          end else if (target_tdata == START_BYTE) begin
            // A new START inside a frame aborts the partial frame and restarts.
            emit            = hold_valid_reg;
            emit_beat.last  = 1'b1;
            emit_beat.user  = 1'b1;
            hold_valid_next = 1'b0;
            len_next        = '0;
          end else begin
            take_payload = 1'b1;
          end
        end
        ESC: begin
          take_payload = 1'b1;
        end
        default: begin
          if (target_tdata == STOP_BYTE) begin
            state_next = HUNT;
          end else if (target_tdata == START_BYTE) begin
            state_next      = DATA;
            len_next        = '0;
            hold_valid_next = 1'b0;
          end
        end
      endcase
    end

    if (take_payload) begin
      if (len_reg == LEN_W'(MAX_LEN)) begin
        // Overlength: close the frame as aborted on the held byte, drop the rest.
        emit            = 1'b1;
        emit_beat.last  = 1'b1;
        emit_beat.user  = 1'b1;
        hold_valid_next = 1'b0;
        state_next      = DISCARD;
      end else begin
        emit            = hold_valid_reg;
        hold_data_next  = target_tdata;
        hold_valid_next = 1'b1;
        len_next        = len_reg + LEN_W'(1);
        state_next      = DATA;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg      <= HUNT;
      hold_data_reg  <= 8'h00;
      hold_valid_reg <= 1'b0;
      len_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      hold_data_reg  <= hold_data_next;
      hold_valid_reg <= hold_valid_next;
      len_reg        <= len_next;
    end
  end

  axis_deframer_oreg u_oreg (
    .aclk             (aclk),
    .areset           (areset),
    .load             (emit),
    .load_beat        (emit_beat),
    .load_ready       (target_tready),
    .initiator_tvalid (initiator_tvalid),
    .initiator_tready (initiator_tready),
    .initiator_tdata  (initiator_tdata),
    .initiator_tlast  (initiator_tlast),
    .initiator_tuser  (initiator_tuser)
  );

`ifdef AXIS_DEFRAMER_STATS_EN
  logic [31:0] frame_cnt_reg;
  logic [31:0] err_cnt_reg;

  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_cnt_reg <= 32'd0;
      err_cnt_reg   <= 32'd0;
    end else if (initiator_tvalid && initiator_tready && initiator_tlast) begin
      if (initiator_tuser) err_cnt_reg <= err_cnt_reg + 32'd1;
      else                 frame_cnt_reg <= frame_cnt_reg + 32'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign err_cnt   = err_cnt_reg;
`endif

endmodule

// File: tb/tb_axis_deframer.sv
// Scoreboard bench for axis_deframer (MAX_LEN=4); stimulus pushes expected
// beats, a negedge monitor pops and compares every accepted output beat.
module tb_axis_deframer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        target_tvalid = 1'b0;
  logic        target_tready;
  logic [7:0]  target_tdata = 8'h00;
  logic        initiator_tvalid;
  logic        initiator_tready = 1'b1;
  logic [7:0]  initiator_tdata;
  logic        initiator_tlast;
  logic        initiator_tuser;
`ifdef AXIS_DEFRAMER_STATS_EN
  logic [31:0] frame_cnt;
  logic [31:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_got;
  logic [9:0] mon_want;
  bit   rand_en = 1'b0;
  logic ready_fix = 1'b1;

  always #5 aclk = ~aclk;

  axis_deframer #(.MAX_LEN(4)) dut (
    .aclk             (aclk),
    .areset           (areset),
    .target_tvalid    (target_tvalid),
    .target_tready    (target_tready),
    .target_tdata     (target_tdata),
    .initiator_tvalid (initiator_tvalid),
    .initiator_tready (initiator_tready),
    .initiator_tdata  (initiator_tdata),
    .initiator_tlast  (initiator_tlast),
    .initiator_tuser  (initiator_tuser)
`ifdef AXIS_DEFRAMER_STATS_EN
    ,
    .frame_cnt        (frame_cnt),
    .err_cnt          (err_cnt)
`endif
  );

  always @(posedge aclk) begin
    #1;
    initiator_tready = rand_en ? ($urandom_range(0, 99) < 30) : ready_fix;
  end

  always @(negedge aclk) begin
    if (!areset && initiator_tvalid && initiator_tready) begin
      mon_got = {initiator_tdata, initiator_tlast, initiator_tuser};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got data=%h last=%b user=%b, required none",
                 initiator_tdata, initiator_tlast, initiator_tuser);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          errors++;
          $display("FAIL beat got data=%h last=%b user=%b, required data=%h last=%b user=%b",
                   mon_got[9:2], mon_got[1], mon_got[0], mon_want[9:2], mon_want[1], mon_want[0]);
        end else begin
          $display("beat data=%h last=%b user=%b ok", mon_got[9:2], mon_got[1], mon_got[0]);
        end
      end
    end
  end

  task automatic expect_beat(input logic [7:0] d, input logic l, input logic u);
    exp_q.push_back({d, l, u});
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    int n = 0;
    target_tvalid = 1'b1;
    target_tdata  = b;
    while (!ok && n < 1000) begin
      @(negedge aclk);
      ok = target_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    target_tvalid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte=%h got target_tready=0, required 1", b);
    end
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain got %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    rand_en   = 1'b0;
    ready_fix = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
  endtask

  task automatic check_idle(input string name);
    @(negedge aclk);
    checks++;
    if (initiator_tvalid !== 1'b0 || initiator_tlast !== 1'b0 || initiator_tuser !== 1'b0) begin
      errors++;
      $display("FAIL %s got tvalid=%b tlast=%b tuser=%b, required 0 0 0",
               name, initiator_tvalid, initiator_tlast, initiator_tuser);
    end
  endtask

  task automatic check_reset_state(input string name);
    check_idle(name);
    checks++;
    if (initiator_tdata !== 8'h00 || target_tready !== 1'b1) begin
      errors++;
      $display("FAIL %s got tdata=%h target_tready=%b, required 00 1",
               name, initiator_tdata, target_tready);
    end
  endtask

`ifdef AXIS_DEFRAMER_STATS_EN
  task automatic check_stats(input string name, input int good, input int bad);
    checks++;
    if (frame_cnt !== 32'(good) || err_cnt !== 32'(bad)) begin
      errors++;
      $display("FAIL %s got frame_cnt=%0d err_cnt=%0d, required %0d %0d",
               name, frame_cnt, err_cnt, good, bad);
    end
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int len;

    repeat (3) @(posedge aclk);
    check_reset_state("reset");
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Plain frame
    expect_beat(8'h01, 1'b0, 1'b0);
    expect_beat(8'h02, 1'b0, 1'b0);
    expect_beat(8'h03, 1'b1, 1'b0);
    send_list('{8'h7D, 8'h01, 8'h02, 8'h03, 8'h7E});
    drain("plain");

    // Escaped delimiters, including escaped START
    expect_beat(8'h7E, 1'b0, 1'b0);
    expect_beat(8'h7D, 1'b0, 1'b0);
    expect_beat(8'h7F, 1'b1, 1'b0);
    send_list('{8'h7D, 8'h7F, 8'h7E, 8'h7F, 8'h7D, 8'h7F, 8'h7F, 8'h7E});
    drain("escape");

    // START mid-frame aborts, next frame continues
    expect_beat(8'hAA, 1'b0, 1'b0);
    expect_beat(8'hBB, 1'b1, 1'b1);
    expect_beat(8'hCC, 1'b1, 1'b0);
    send_list('{8'h7D, 8'hAA, 8'hBB, 8'h7D, 8'hCC, 8'h7E});
    drain("abort");

    // Overlength at MAX_LEN=4, then recovery
    expect_beat(8'h01, 1'b0, 1'b0);
    expect_beat(8'h02, 1'b0, 1'b0);
    expect_beat(8'h03, 1'b0, 1'b0);
    expect_beat(8'h04, 1'b1, 1'b1);
    expect_beat(8'h09, 1'b1, 1'b0);
    send_list('{8'h7D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h7E, 8'h7D, 8'h09, 8'h7E});
    drain("overlength");

    // Exactly MAX_LEN is good; empty and START,START frames emit nothing
    expect_beat(8'hA1, 1'b0, 1'b0);
    expect_beat(8'hA2, 1'b0, 1'b0);
    expect_beat(8'hA3, 1'b0, 1'b0);
    expect_beat(8'hA4, 1'b1, 1'b0);
    expect_beat(8'h55, 1'b1, 1'b0);
    send_list('{8'h7D, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h7E, 8'h7D, 8'h7E,
                8'h7D, 8'h7D, 8'h7E, 8'h7D, 8'h55, 8'h7E});
    drain("boundary");
    check_idle("boundary_idle");
`ifdef AXIS_DEFRAMER_STATS_EN
    check_stats("stats_directed", 6, 2);
`endif

    // Random 30% output ready over 200 frames with random payloads
    rand_en = 1'b1;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 4);
      send_byte(8'h7D);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        expect_beat(b, (i == len - 1), 1'b0);
        if (b == 8'h7D || b == 8'h7E || b == 8'h7F) send_byte(8'h7F);
        send_byte(b);
      end
      send_byte(8'h7E);
      if (f % 20 == 0) send_list('{8'h7D, 8'h7E});
    end
    drain("random");
    check_idle("random_idle");

    // Reset mid-frame: held byte is dropped
    ready_fix = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    send_list('{8'h7D, 8'h11, 8'h22});
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    check_reset_state("mid_reset");
    @(posedge aclk);
    #1;
    areset    = 1'b0;
    ready_fix = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    expect_beat(8'h33, 1'b1, 1'b0);
    send_list('{8'h7D, 8'h33, 8'h7E});
    drain("after_reset");
    check_idle("final_idle");
`ifdef AXIS_DEFRAMER_STATS_EN
    check_stats("stats_after_reset", 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
